// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (I/D) and memory bus signals for mem_port_arbiter.
// slave = arbiter side, master = environment (pipeline ports and memory).
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rd;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wd;
  logic [31:0] d_rd;
  logic        d_ready;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ack;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wd, mem_rd, mem_ack,
    output i_rd, i_ready, d_rd, d_ready, err, mem_req, mem_we, mem_addr, mem_wd
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wd, mem_rd, mem_ack,
    input  i_rd, i_ready, d_rd, d_ready, err, mem_req, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates I-fetch and D ports onto one variable-latency memory, with a no-ack watchdog.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration (default: D over I fixed priority).
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD, StDone} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        cur_d_q, cur_d_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [31:0] i_rd_q, i_rd_d;
  logic [31:0] d_rd_q, d_rd_d;
  logic        elig_i, elig_d, pick_d;

  // The port whose ready is high this cycle is masked so a stale req is not re-granted.
  assign elig_i = bus.i_req & ~((state_q == StDone) & ~cur_d_q);
  assign elig_d = bus.d_req & ~((state_q == StDone) & cur_d_q);

`ifdef MEM_PORT_ARB_RR_EN
  logic last_d_q;

  assign pick_d = elig_d & (~elig_i | ~last_d_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if ((state_q == StIdle || state_q == StDone) && (elig_i || elig_d)) begin
      last_d_q <= pick_d;
    end
  end
`else
  assign pick_d = elig_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    cur_d_d    = cur_d_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    i_rd_d     = i_rd_q;
    d_rd_d     = d_rd_q;

    unique case (state_q)
      StIdle, StDone: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = StIdle;
        if (elig_i || elig_d) begin
          state_d    = pick_d ? StGntD : StGntI;
          cur_d_d    = pick_d;
          mem_req_d  = 1'b1;
          mem_we_d   = pick_d & bus.d_we;
          mem_addr_d = pick_d ? bus.d_addr : bus.i_addr;
          if (pick_d) mem_wd_d = bus.d_wd;
        end
      end
      StGntI, StGntD: begin
        if (bus.mem_ack) begin
          if (state_q == StGntI) i_rd_d = bus.mem_rd;
          else if (!mem_we_q)    d_rd_d = bus.mem_rd;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StDone;
        end else if (cnt_q == TimeoutLast) begin
          if (state_q == StGntI) i_rd_d = 32'hffff_ffff;
          else                   d_rd_d = 32'hffff_ffff;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      cur_d_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      i_rd_q     <= '0;
      d_rd_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      cur_d_q    <= cur_d_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      i_rd_q     <= i_rd_d;
      d_rd_q     <= d_rd_d;
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.i_rd     = i_rd_q;
  assign bus.d_rd     = d_rd_q;
  assign bus.i_ready  = (state_q == StDone) & ~cur_d_q;
  assign bus.d_ready  = (state_q == StDone) & cur_d_q;
  assign bus.err      = (state_q == StDone) & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal checks plus randomized traffic against a
// transaction-level model of the two ports and the memory watchdog.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner of the memory (0 none, 1 I, 2 D), cycles it has held mem_req,
  // port completing this cycle, and the expected output values.
  int          m_busy, m_cyc, m_done;
  bit          m_err, m_last_d;
  logic        e_mem_req, e_mem_we;
  logic [31:0] e_mem_addr, e_mem_wd, e_i_rd, e_d_rd;

  // Memory responder state.
  bit rand_mode = 0;
  int force_lat = 0;
  int cur_lat   = 0;
  int hi_cnt    = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cyc = 0; m_done = 0; m_err = 0; m_last_d = 0;
    e_mem_req = 0; e_mem_we = 0;
    e_mem_addr = '0; e_mem_wd = '0; e_i_rd = '0; e_d_rd = '0;
  endtask

  // Predict the effect of the coming rising edge from the inputs currently driven.
  task automatic model_step();
    int  nd = 0;
    bit  ne = 0;
    bit  ei, ed;
    int  w = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_busy != 0) begin
      if (bus.mem_ack) begin
        if (m_busy == 1) e_i_rd = bus.mem_rd;
        else if (!e_mem_we) e_d_rd = bus.mem_rd;
        nd = m_busy;
      end else if (m_cyc + 1 == TO) begin
        if (m_busy == 1) e_i_rd = 32'hffff_ffff;
        else e_d_rd = 32'hffff_ffff;
        ne = 1;
        nd = m_busy;
      end else begin
        m_cyc++;
      end
      if (nd != 0) begin
        e_mem_req = 0; e_mem_we = 0; m_busy = 0;
      end
    end else begin
      ei = bus.i_req && (m_done != 1);
      ed = bus.d_req && (m_done != 2);
`ifdef MEM_PORT_ARB_RR_EN
      if (ei && ed) w = m_last_d ? 1 : 2;
`else
      if (ei && ed) w = 2;
`endif
      else if (ed) w = 2;
      else if (ei) w = 1;
      if (w != 0) begin
        m_busy     = w;
        m_cyc      = 0;
        m_last_d   = (w == 2);
        e_mem_req  = 1;
        e_mem_we   = (w == 2) && bus.d_we;
        e_mem_addr = (w == 2) ? bus.d_addr : bus.i_addr;
        if (w == 2) e_mem_wd = bus.d_wd;
      end
    end
    m_done = nd;
    m_err  = ne;
  endtask

  task automatic compare_all();
    check32("mem_req", bus.mem_req, e_mem_req);
    check32("mem_we", bus.mem_we, e_mem_we);
    check32("mem_addr", bus.mem_addr, e_mem_addr);
    check32("mem_wd", bus.mem_wd, e_mem_wd);
    check32("i_rd", bus.i_rd, e_i_rd);
    check32("d_rd", bus.d_rd, e_d_rd);
    check32("i_ready", bus.i_ready, m_done == 1);
    check32("d_ready", bus.d_ready, m_done == 2);
    check32("err", bus.err, (m_done != 0) && m_err);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Ack cur_lat cycles after mem_req rises; latency >= TO means the ack never comes.
  task automatic drive_mem();
    if (e_mem_req) begin
      if (hi_cnt == 0) cur_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
      bus.mem_ack = (hi_cnt == cur_lat);
      hi_cnt++;
    end else begin
      hi_cnt = 0;
      bus.mem_ack = rand_mode && ($urandom_range(0, 7) == 0);
    end
    if (rand_mode) bus.mem_rd = $urandom;
  endtask

  task automatic xfer(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdata, input int lat, output int ticks, output int hi,
                      output logic e, output logic saw_we, output logic [31:0] saw_wd);
    logic done = 0;
    if (is_d) begin
      bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wd = wd;
    end else begin
      bus.i_req = 1; bus.i_addr = addr;
    end
    force_lat = lat;
    bus.mem_rd = rdata;
    ticks = 0; hi = 0; e = 0; saw_we = 0; saw_wd = '0;
    for (int t = 0; t < 40 && !done; t++) begin
      drive_mem();
      tick();
      ticks++;
      if (bus.mem_req) begin
        hi++;
        if (hi == 1) begin
          saw_we = bus.mem_we;
          saw_wd = bus.mem_wd;
        end
      end
      if (is_d ? bus.d_ready : bus.i_ready) begin
        e = bus.err;
        done = 1;
      end
    end
    check32("xfer_completed", done, 1);
    bus.i_req = 0;
    bus.d_req = 0;
    drive_mem();
    tick();
  endtask

  initial begin : main
    int          tk, hi, grants, pulses, consec, d_t, i_t;
    logic        e, swe, prev_req, prev_rdy;
    logic [31:0] swd;
    logic [31:0] g_addr [2];
    int          g_tick [2];
    bit          i_pend, d_pend;

    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wd = '0; bus.mem_rd = '0; bus.mem_ack = 0;
    model_reset();
    #1;
    check32("rst_mem_req", bus.mem_req, 0);
    check32("rst_mem_we", bus.mem_we, 0);
    check32("rst_mem_addr", bus.mem_addr, 0);
    check32("rst_mem_wd", bus.mem_wd, 0);
    check32("rst_i_rd", bus.i_rd, 0);
    check32("rst_d_rd", bus.d_rd, 0);
    check32("rst_i_ready", bus.i_ready, 0);
    check32("rst_d_ready", bus.d_ready, 0);
    check32("rst_err", bus.err, 0);
    @(negedge clk);
    rst = 0;

    // Fetch, ack two cycles after mem_req: ready at 2 + latency edges after request.
    xfer(0, 0, 32'h100, 0, 32'hdeadbeef, 2, tk, hi, e, swe, swd);
    check32("t1_ticks", tk, 4);
    check32("t1_i_rd", bus.i_rd, 32'hdeadbeef);
    check32("t1_mem_addr", bus.mem_addr, 32'h100);
    check32("t1_mem_we", swe, 0);
    check32("t1_err", e, 0);

    // Data write with immediate ack.
    xfer(1, 1, 32'h20, 32'h12345678, 32'hcafef00d, 0, tk, hi, e, swe, swd);
    check32("t2_ticks", tk, 2);
    check32("t2_mem_we", swe, 1);
    check32("t2_mem_wd", swd, 32'h12345678);
    check32("t2_d_rd", bus.d_rd, 0);
    check32("t2_err", e, 0);

    // Watchdog: no ack ever.
    xfer(1, 0, 32'h40, 0, 32'h55555555, 100, tk, hi, e, swe, swd);
    check32("t4_ticks", tk, TO + 1);
    check32("t4_req_cycles", hi, TO);
    check32("t4_err", e, 1);
    check32("t4_d_rd", bus.d_rd, 32'hffffffff);
    xfer(1, 0, 32'h44, 0, 32'h0badf00d, 1, tk, hi, e, swe, swd);
    check32("t4b_ticks", tk, 3);
    check32("t4b_err", e, 0);
    check32("t4b_d_rd", bus.d_rd, 32'h0badf00d);

    // Simultaneous requests after reset (last grant = I): D first, then I right after D's DONE.
    rst = 1;
    model_reset();
    tick();
    rst = 0;
    bus.i_req = 1; bus.i_addr = 32'h300;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
    force_lat = 1;
    grants = 0; prev_req = 0; d_t = -1; i_t = -1;
    g_addr[0] = '0; g_addr[1] = '0; g_tick[0] = 0; g_tick[1] = 0;
    for (int t = 1; t <= 20; t++) begin
      drive_mem();
      tick();
      if (bus.mem_req && !prev_req) begin
        if (grants < 2) begin
          g_addr[grants] = bus.mem_addr;
          g_tick[grants] = t;
        end
        grants++;
      end
      prev_req = bus.mem_req;
      if (bus.d_ready) begin bus.d_req = 0; d_t = t; end
      if (bus.i_ready) begin bus.i_req = 0; i_t = t; end
    end
    check32("t3_grants", grants, 2);
    check32("t3_first", g_addr[0], 32'h400);
    check32("t3_second", g_addr[1], 32'h300);
    check32("t3_back_to_back", g_tick[1], d_t + 1);
    check32("t3_i_done", i_t > d_t, 1);

    // Asynchronous reset in the middle of a fetch.
    bus.i_req = 1; bus.i_addr = 32'h500; force_lat = 50;
    drive_mem(); tick();
    drive_mem(); tick();
    check32("t5_pre_mem_req", bus.mem_req, 1);
    #2 rst = 1;
    model_reset();
    #1;
    check32("t5_async_mem_req", bus.mem_req, 0);
    check32("t5_async_i_ready", bus.i_ready, 0);
    bus.i_req = 0;
    drive_mem(); tick();
    rst = 0;
    xfer(0, 0, 32'h500, 0, 32'h600df00d, 1, tk, hi, e, swe, swd);
    check32("t5_ticks", tk, 3);
    check32("t5_i_rd", bus.i_rd, 32'h600df00d);

    // Fetch held high with zero-latency memory: one completion per three cycles.
    bus.i_req = 1; bus.i_addr = 32'h600; force_lat = 0;
    pulses = 0; consec = 0; prev_rdy = 0;
    for (int t = 0; t < 12; t++) begin
      drive_mem();
      tick();
      if (bus.i_ready) begin
        pulses++;
        if (prev_rdy) consec++;
      end
      prev_rdy = bus.i_ready;
    end
    check32("t6_pulses", pulses, 4);
    check32("t6_consecutive", consec, 0);
    bus.i_req = 0;
    drive_mem(); tick();
    drive_mem(); tick();

    // Randomized traffic, including spurious acks and requests issued in the ready cycle.
    rand_mode = 1;
    force_lat = -1;
    i_pend = 0; d_pend = 0;
    for (int t = 0; t < 4000; t++) begin
      if (i_pend && m_done == 1) i_pend = 0;
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1;
        bus.i_addr = $urandom;
      end
      if (d_pend && m_done == 2) d_pend = 0;
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1;
        bus.d_we = $urandom_range(0, 1) == 1;
        bus.d_addr = $urandom;
        bus.d_wd = $urandom;
      end
      bus.i_req = i_pend;
      bus.d_req = d_pend;
      drive_mem();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
